// File: rtl/prog_state_sequencer_pkg.sv
// Shared helpers for the programmable sequencer: default table contents
// and the legal-index check used by both write-accept and state recovery.
package seq_pkg;

    function automatic int default_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

    function automatic logic default_out(input int idx);
        return (idx == 0);
    endfunction

    function automatic logic is_legal(input int idx, input int n);
        return (idx < n);
    endfunction

endpackage

// File: rtl/prog_state_sequencer_table.sv
// N_STATES x (SW+1) next-state/output register file with one write port
// and a combinational read at the current state.
module seq_table
    import seq_pkg::*;
#(
    parameter int N_STATES = 8,
    parameter int SW       = $clog2(N_STATES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [SW-1:0] wr_next,
    input  logic          wr_out,
    output logic          wr_reject,
    input  logic [SW-1:0] rd_addr,
    output logic [SW-1:0] rd_next,
    output logic          rd_out
);

    logic [SW-1:0] next_tbl [N_STATES];
    logic          out_tbl  [N_STATES];
    logic          wr_legal;
    logic          wr_accept;
    logic          rd_legal;

    assign wr_legal  = is_legal(int'(32'(wr_addr)), N_STATES) &&
                       is_legal(int'(32'(wr_next)), N_STATES);
    assign wr_accept = wr_en && wr_legal;
    assign wr_reject = wr_en && !wr_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_STATES; i++) begin
                next_tbl[i] <= SW'(default_next(i, N_STATES));
                out_tbl[i]  <= default_out(i);
            end
        end else if (wr_accept) begin
            next_tbl[wr_addr] <= wr_next;
            out_tbl[wr_addr]  <= wr_out;
        end
    end

    // Out-of-range reads (corrupted state) resolve to state 0 with output low.
    assign rd_legal = is_legal(int'(32'(rd_addr)), N_STATES);

    always_comb begin
        rd_next = '0;
        rd_out  = 1'b0;
        if (rd_legal) begin
            rd_next = next_tbl[rd_addr];
            rd_out  = out_tbl[rd_addr];
        end
    end

endmodule

// File: rtl/prog_state_sequencer.sv
// Table-driven Moore sequencer: state register, advance mux, self-loop
// detection and a one-cycle flag for rejected table writes.
module prog_state_sequencer
    import seq_pkg::*;
#(
    parameter int N_STATES    = 8,
    parameter int START_STATE = 0,
    localparam int SW         = $clog2(N_STATES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [SW-1:0] wr_next,
    input  logic          wr_out,
    output logic [SW-1:0] state,
    output logic          y,
    output logic          hold,
    output logic          wr_err
);

    localparam logic [SW-1:0] START = SW'(START_STATE);

    logic [SW-1:0] tbl_next;
    logic          tbl_out;
    logic          wr_reject;
    logic          state_ok;

    seq_table #(
        .N_STATES (N_STATES),
        .SW       (SW)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_next   (wr_next),
        .wr_out    (wr_out),
        .wr_reject (wr_reject),
        .rd_addr   (state),
        .rd_next   (tbl_next),
        .rd_out    (tbl_out)
    );

    assign state_ok = is_legal(int'(32'(state)), N_STATES);

    // Advance reads the pre-write table: a same-cycle write lands on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= START;
        end else if (en) begin
            state <= tbl_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_reject;
        end
    end

    assign y    = state_ok && tbl_out;
    assign hold = state_ok && (tbl_next == state);

endmodule

// File: tb/tb_prog_state_sequencer.sv
// Bench for prog_state_sequencer: an 8-state instance driven from a vector
// table and a 5-state instance checked against a behavioural model.
module tb_prog_state_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       en8, we8, wo8, en5, we5, wo5;
    logic [2:0] wa8, wn8, wa5, wn5;
    logic [2:0] state8, state5;
    logic       y8, hold8, err8, y5, hold5, err5;

    prog_state_sequencer #(.N_STATES(8), .START_STATE(0)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .wr_en(we8), .wr_addr(wa8),
        .wr_next(wn8), .wr_out(wo8), .state(state8), .y(y8), .hold(hold8),
        .wr_err(err8)
    );

    prog_state_sequencer #(.N_STATES(5), .START_STATE(0)) dut5 (
        .clk(clk), .reset(reset), .en(en5), .wr_en(we5), .wr_addr(wa5),
        .wr_next(wn5), .wr_out(wo5), .state(state5), .y(y5), .hold(hold5),
        .wr_err(err5)
    );

    typedef struct {
        logic       en, we;
        logic [2:0] addr, nxt;
        logic       out;
        logic [2:0] st;
        logic       y, hold, err;
    } vec_t;

    typedef struct {
        int         dut;
        logic [2:0] st;
        logic       y, hold, err;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    int   m_next[5];
    logic m_out[5];
    int   m_st;
    logic m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic void v(input logic en, input logic we, input int a, input int n,
                              input logic o, input int st, input logic y, input logic h,
                              input logic e);
        vec_t t;
        t.en = en; t.we = we; t.addr = 3'(a); t.nxt = 3'(n); t.out = o;
        t.st = 3'(st); t.y = y; t.hold = h; t.err = e;
        vecs.push_back(t);
    endfunction

    task automatic compare_pop();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.dut == 8) begin
                chk({e.tag, ".state"}, 32'(state8), 32'(e.st));
                chk({e.tag, ".y"},     32'(y8),     32'(e.y));
                chk({e.tag, ".hold"},  32'(hold8),  32'(e.hold));
                chk({e.tag, ".wr_err"},32'(err8),   32'(e.err));
            end else begin
                chk({e.tag, ".state"}, 32'(state5), 32'(e.st));
                chk({e.tag, ".y"},     32'(y5),     32'(e.y));
                chk({e.tag, ".hold"},  32'(hold5),  32'(e.hold));
                chk({e.tag, ".wr_err"},32'(err5),   32'(e.err));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic run_vecs(input string tag);
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            en8 = vecs[i].en; we8 = vecs[i].we; wa8 = vecs[i].addr;
            wn8 = vecs[i].nxt; wo8 = vecs[i].out;
            e.dut = 8; e.st = vecs[i].st; e.y = vecs[i].y;
            e.hold = vecs[i].hold; e.err = vecs[i].err;
            e.tag = $sformatf("%s[%0d]", tag, i);
            sbq.push_back(e);
            tick();
        end
        vecs.delete();
        en8 = 0; we8 = 0; wa8 = 0; wn8 = 0; wo8 = 0;
    endtask

    function automatic void m5_reset();
        for (int i = 0; i < 5; i++) begin
            m_next[i] = (i + 1) % 5;
            m_out[i]  = (i == 0);
        end
        m_st  = 0;
        m_err = 1'b0;
    endfunction

    task automatic m5_step(input logic en, input logic we, input int a, input int n,
                           input logic o, input string tag);
        exp_t e;
        int   ns;
        logic bad;
        en5 = en; we5 = we; wa5 = 3'(a); wn5 = 3'(n); wo5 = o;
        ns  = en ? ((m_st < 5) ? m_next[m_st] : 0) : m_st;
        bad = we && !(a < 5 && n < 5);
        if (we && !bad) begin
            m_next[a] = n;
            m_out[a]  = o;
        end
        m_st  = ns;
        m_err = bad;
        e.dut = 5; e.st = 3'(m_st); e.y = m_out[m_st];
        e.hold = (m_next[m_st] == m_st); e.err = m_err;
        e.tag = tag;
        sbq.push_back(e);
        tick();
        en5 = 0; we5 = 0; wa5 = 0; wn5 = 0; wo5 = 0;
    endtask

    initial begin
        reset = 1'b1;
        en8 = 0; we8 = 0; wa8 = 0; wn8 = 0; wo8 = 0;
        en5 = 0; we5 = 0; wa5 = 0; wn5 = 0; wo5 = 0;
        m5_reset();
        #12;
        chk("rst8.state", 32'(state8), 32'd0);
        chk("rst8.y",     32'(y8),     32'd1);
        chk("rst8.hold",  32'(hold8),  32'd0);
        chk("rst8.wr_err",32'(err8),   32'd0);
        chk("rst5.state", 32'(state5), 32'd0);
        chk("rst5.y",     32'(y5),     32'd1);
        reset = 1'b0;

        // Free-running count, then wrap back to 0.
        for (int i = 1; i <= 16; i++) v(1, 0, 0, 0, 0, i % 8, (i % 8) == 0, 0, 0);
        // Reprogram at state 0 with en low.
        v(0, 1, 0, 4, 1, 0, 1, 0, 0);
        v(0, 1, 4, 7, 1, 0, 1, 0, 0);
        v(0, 1, 7, 2, 0, 0, 1, 0, 0);
        v(0, 1, 2, 1, 0, 0, 1, 0, 0);
        v(0, 1, 1, 2, 0, 0, 1, 0, 0);
        v(1, 0, 0, 0, 0, 4, 1, 0, 0);
        v(1, 0, 0, 0, 0, 7, 0, 0, 0);
        v(1, 0, 0, 0, 0, 2, 0, 0, 0);
        v(1, 0, 0, 0, 0, 1, 0, 0, 0);
        v(1, 0, 0, 0, 0, 2, 0, 0, 0);
        v(1, 0, 0, 0, 0, 1, 0, 0, 0);
        // Walk to 3, then write-while-advancing on the current entry.
        v(0, 1, 2, 3, 0, 1, 0, 0, 0);
        v(1, 0, 0, 0, 0, 2, 0, 0, 0);
        v(1, 0, 0, 0, 0, 3, 0, 0, 0);
        v(1, 1, 3, 3, 0, 4, 1, 0, 0);
        v(1, 0, 0, 0, 0, 7, 0, 0, 0);
        v(1, 0, 0, 0, 0, 2, 0, 0, 0);
        v(1, 0, 0, 0, 0, 3, 0, 1, 0);
        v(1, 0, 0, 0, 0, 3, 0, 1, 0);
        v(1, 1, 3, 5, 0, 3, 0, 0, 0);
        v(1, 0, 0, 0, 0, 5, 0, 0, 0);
        run_vecs("seq8");

        // Five-state instance: rejected writes leave the table intact.
        for (int i = 0; i < 5; i++) m5_step(1, 0, 0, 0, 0, $sformatf("cnt5[%0d]", i));
        m5_step(0, 1, 6, 1, 1, "bad_addr");
        m5_step(0, 0, 0, 0, 0, "bad_addr_idle");
        m5_step(0, 1, 2, 7, 0, "bad_next");
        m5_step(0, 0, 0, 0, 0, "bad_next_idle");
        m5_step(1, 1, 6, 0, 0, "bad_adv");
        for (int i = 0; i < 4; i++) m5_step(1, 0, 0, 0, 0, $sformatf("after5[%0d]", i));
        m5_step(0, 1, 0, 0, 0, "self0");
        m5_step(1, 0, 0, 0, 0, "self0_adv");

        // Asynchronous reset mid-cycle from state 5 with a reprogrammed table.
        chk("pre_rst.state", 32'(state8), 32'd5);
        #2;
        reset = 1'b1;
        m5_reset();
        #1;
        chk("mid_rst.state", 32'(state8), 32'd0);
        chk("mid_rst.y",     32'(y8),     32'd1);
        chk("mid_rst.hold",  32'(hold8),  32'd0);
        chk("mid_rst.wr_err",32'(err8),   32'd0);
        chk("mid_rst5.state",32'(state5), 32'd0);
        en8 = 1'b1;
        @(posedge clk);
        #1;
        chk("in_rst.state",  32'(state8), 32'd0);
        #1;
        reset = 1'b0;
        en8 = 1'b0;

        // en toggling, then a full lap over the restored default table.
        v(1, 0, 0, 0, 0, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 0, 0, 0);
        v(1, 0, 0, 0, 0, 2, 0, 0, 0);
        for (int i = 3; i <= 8; i++) v(1, 0, 0, 0, 0, i % 8, (i % 8) == 0, 0, 0);
        run_vecs("post8");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
